// File: rtl/rom_loader.sv
// rom_loader: assembles downloaded bytes into 32-bit words and writes them to SDRAM.
// Define ROM_LOADER_CHECKSUM_EN to build the additive byte checksum; otherwise checksum is 0.

module rom_loader (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  output logic [22:0] sdram_addr,
  output logic [31:0] sdram_data,
  output logic        sdram_we,
  output logic        sdram_req,
  input  logic        sdram_ack,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [7:0]  checksum
);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_FLUSH, S_DONE} state_e;

  state_e          state_q, state_d;
  logic            dl_q;
  logic [3:0][7:0] asm_q, asm_d;
  logic [3:0]      lanes_q, lanes_d;
  logic [22:0]     last_addr_q, last_addr_d;
  logic            pend_full_q, pend_full_d;
  logic [22:0]     pend_addr_q, pend_addr_d;
  logic [31:0]     pend_data_q, pend_data_d;
  logic            out_full_q, out_full_d;
  logic [22:0]     out_addr_q, out_addr_d;
  logic [31:0]     out_data_q, out_data_d;
  logic            req_q, req_d;
  logic            ovf_q, ovf_d;

  logic        enter_active, ack_take, load, pend_free, push;
  logic [22:0] push_addr;
  logic [31:0] push_data;

  assign enter_active = (state_q == S_IDLE || state_q == S_DONE) && ioctl_download && !dl_q;
  assign ack_take     = req_q && sdram_ack;
  // The output stage holds the word on the bus; the pending register queues one more behind it.
  assign load         = pend_full_q && (!out_full_q || ack_take);
  assign pend_free    = !pend_full_q || load;

  // NOTE: every signal gets its default first so no path through this block infers a latch.
  always_comb begin
    state_d     = state_q;
    asm_d       = asm_q;
    lanes_d     = lanes_q;
    last_addr_d = last_addr_q;
    pend_full_d = pend_full_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    out_full_d  = out_full_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    req_d       = req_q;
    ovf_d       = ovf_q;
    push        = 1'b0;
    push_addr   = '0;
    push_data   = '0;

    // An ack that hands over a queued word drops req for one cycle before re-raising it.
    if (load) begin
      out_addr_d  = pend_addr_q;
      out_data_d  = pend_data_q;
      out_full_d  = 1'b1;
      pend_full_d = 1'b0;
      req_d       = !out_full_q;
    end else if (ack_take) begin
      out_full_d = 1'b0;
      req_d      = 1'b0;
    end else if (out_full_q && !req_q) begin
      req_d = 1'b1;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (enter_active) begin
          state_d = S_ACTIVE;
          ovf_d   = 1'b0;
          lanes_d = '0;
          asm_d   = '0;
        end
      end
      S_ACTIVE: begin
        if (ioctl_wr) begin
          asm_d[ioctl_addr[1:0]]   = ioctl_data;
          lanes_d[ioctl_addr[1:0]] = 1'b1;
          last_addr_d              = ioctl_addr[24:2];
          if (ioctl_addr[1:0] == 2'd3) begin
            push      = 1'b1;
            push_addr = ioctl_addr[24:2];
            push_data = asm_d;
          end
        end
        if (!ioctl_download) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (|lanes_q) begin
          if (pend_free) begin
            push      = 1'b1;
            push_addr = last_addr_q;
            push_data = asm_q;
          end
        end else if (!pend_full_q && !out_full_q) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A completed word leaves the assembly register whether it is queued or lost.
    if (push) begin
      lanes_d = '0;
      asm_d   = '0;
      if (pend_free) begin
        pend_full_d = 1'b1;
        pend_addr_d = push_addr;
        pend_data_d = push_data;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      dl_q        <= 1'b0;
      asm_q       <= '0;
      lanes_q     <= '0;
      last_addr_q <= '0;
      pend_full_q <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      out_full_q  <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      req_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dl_q        <= ioctl_download;
      asm_q       <= asm_d;
      lanes_q     <= lanes_d;
      last_addr_q <= last_addr_d;
      pend_full_q <= pend_full_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
      out_full_q  <= out_full_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      req_q       <= req_d;
      ovf_q       <= ovf_d;
    end
  end

  assign sdram_addr = out_addr_q;
  assign sdram_data = out_data_q;
  assign sdram_req  = req_q;
  assign sdram_we   = req_q;
  assign busy       = (state_q == S_ACTIVE) || (state_q == S_FLUSH);
  assign done       = (state_q == S_DONE);
  assign overflow   = ovf_q;

`ifdef ROM_LOADER_CHECKSUM_EN
  logic [7:0] cs_q, cs_d;

  always_comb begin
    cs_d = cs_q;
    if (enter_active)                          cs_d = '0;
    else if (state_q == S_ACTIVE && ioctl_wr)  cs_d = cs_q + ioctl_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cs_q <= '0;
    else          cs_q <= cs_d;
  end

  assign checksum = cs_q;
`else
  assign checksum = 8'h00;
`endif

endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: directed and randomized downloads checked against a transaction-level model
// (a two-deep write queue, byte lanes and download phase) compared on every falling clock edge.

module tb_rom_loader;

  logic        clk = 1'b0;
  logic        reset_n, ioctl_download, ioctl_wr, sdram_ack;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic [22:0] sdram_addr;
  logic [31:0] sdram_data;
  logic        sdram_we, sdram_req, busy, done, overflow;
  logic [7:0]  checksum;

  logic resp_ack, ack_force;
  int   ack_delay, resp_cnt;
  int   n_checks, n_errors;

  always #5 clk = ~clk;
  assign sdram_ack = resp_ack | ack_force;

  rom_loader dut (
    .clk(clk), .reset_n(reset_n), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .sdram_addr(sdram_addr),
    .sdram_data(sdram_data), .sdram_we(sdram_we), .sdram_req(sdram_req), .sdram_ack(sdram_ack),
    .busy(busy), .done(done), .overflow(overflow), .checksum(checksum)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum logic [1:0] {P_IDLE, P_ACTIVE, P_FLUSH, P_DONE} phase_e;
  phase_e      m_phase;
  logic        m_dl_prev, m_ovf;
  logic [7:0]  m_lane [4];
  logic [22:0] m_last;
  logic [7:0]  m_cs;
  logic [54:0] m_q [$];   // {word addr, data}, oldest first
  logic [54:0] wlog [$];  // writes observed at ack
  int          req_cycles, starve;
  logic        prev_req;
  logic [54:0] prev_out;

  function automatic logic lanes_any();
    return (m_lane[0] !== 8'hxx) && 1'b0;
  endfunction

  bit m_lv [4];

  function automatic void clear_lanes();
    for (int i = 0; i < 4; i++) begin m_lane[i] = 8'h00; m_lv[i] = 1'b0; end
  endfunction

  function automatic void model_reset();
    m_phase = P_IDLE; m_dl_prev = 1'b0; m_ovf = 1'b0; m_cs = 8'h00; m_last = '0;
    m_q.delete();
    clear_lanes();
  endfunction

  function automatic void push_word(input logic [22:0] a);
    if (m_q.size() < 2) m_q.push_back({a, m_lane[3], m_lane[2], m_lane[1], m_lane[0]});
    else                m_ovf = 1'b1;
    clear_lanes();
  endfunction

  function automatic logic [7:0] exp_checksum();
`ifdef ROM_LOADER_CHECKSUM_EN
    return m_cs;
`else
    return 8'h00;
`endif
  endfunction

  // Compare DUT state after the last edge, then advance the model by the inputs of the next edge.
  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      check("rst_ctrl", {sdram_req, sdram_we, busy, done, overflow, checksum}, 0);
      check("rst_bus", {sdram_addr, sdram_data}, 0);
      model_reset();
      prev_req = 1'b0;
      starve   = 0;
    end else begin
      int pre_count;
      check("busy", busy, m_phase == P_ACTIVE || m_phase == P_FLUSH);
      check("done", done, m_phase == P_DONE);
      check("overflow", overflow, m_ovf);
      check("checksum", checksum, exp_checksum());
      check("we_eq_req", sdram_we, sdram_req);
      if (sdram_req) begin
        req_cycles++;
        check("req_word", {sdram_addr, sdram_data}, (m_q.size() != 0) ? m_q[0] : 55'hx);
        if (prev_req) check("req_stable", {sdram_addr, sdram_data}, prev_out);
      end
      if (m_q.size() != 0 && !sdram_req) starve++;
      else starve = 0;
      if (m_q.size() != 0) check("req_latency", starve <= 1, 1);
      prev_req = sdram_req;
      prev_out = {sdram_addr, sdram_data};

      pre_count = m_q.size();
      if (sdram_req && sdram_ack) begin
        wlog.push_back({sdram_addr, sdram_data});
        if (m_q.size() != 0) void'(m_q.pop_front());
      end
      case (m_phase)
        P_IDLE, P_DONE: if (ioctl_download && !m_dl_prev) begin
          m_phase = P_ACTIVE; m_ovf = 1'b0; m_cs = 8'h00; clear_lanes();
        end
        P_ACTIVE: begin
          if (ioctl_wr) begin
            m_lane[ioctl_addr[1:0]] = ioctl_data;
            m_lv[ioctl_addr[1:0]]   = 1'b1;
            m_cs   = m_cs + ioctl_data;
            m_last = ioctl_addr[24:2];
            if (ioctl_addr[1:0] == 2'd3) push_word(ioctl_addr[24:2]);
          end
          if (!ioctl_download) m_phase = P_FLUSH;
        end
        P_FLUSH: begin
          if (m_lv[0] || m_lv[1] || m_lv[2] || m_lv[3]) begin
            if (m_q.size() < 2) push_word(m_last);
          end else if (pre_count == 0) begin
            m_phase = P_DONE;
          end
        end
        default: ;
      endcase
      m_dl_prev = ioctl_download;
    end
  end

  // SDRAM responder: acks a request ack_delay cycles after it is first seen, for one cycle.
  initial begin
    resp_ack = 1'b0;
    resp_cnt = 0;
    forever begin
      @(posedge clk);
      #2;
      if (resp_ack) begin
        resp_ack = 1'b0;
        resp_cnt = 0;
      end else if (sdram_req) begin
        resp_cnt++;
        if (resp_cnt > ack_delay) resp_ack = 1'b1;
      end else begin
        resp_cnt = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    ioctl_wr = 1'b1; ioctl_addr = a; ioctl_data = d;
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic start_dl();
    ioctl_download = 1'b1;
    tick();
  endtask

  task automatic end_dl_and_wait(input int budget);
    int n = 0;
    ioctl_download = 1'b0;
    while (!done && n < budget) begin tick(); n++; end
    check("done_reached", done, 1);
  endtask

  task automatic clear_logs();
    wlog.delete();
    req_cycles = 0;
  endtask

  initial begin
    logic [24:0] base;
    int          nbytes;
    n_checks = 0; n_errors = 0;
    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_data = '0;
    ack_force = 1'b0; ack_delay = 2;
    clear_logs();
    repeat (2) @(posedge clk);
    #2;
    check("reset_busy_done", {busy, done, overflow}, 3'b000);
    check("reset_req_sum", {sdram_req, sdram_we, checksum}, 10'h000);
    reset_n = 1'b1;
    tick();

    // Single word, ack two cycles after req.
    clear_logs(); ack_delay = 2;
    start_dl();
    send_byte(25'h0, 8'h11); send_byte(25'h1, 8'h22); send_byte(25'h2, 8'h33); send_byte(25'h3, 8'h44);
    tick();
    check("t1_req_up", {sdram_req, sdram_we}, 2'b11);
    repeat (8) tick();
    check("t1_nwrites", wlog.size(), 1);
    check("t1_write", (wlog.size() != 0) ? wlog[0] : 55'hx, {23'h0, 32'h44332211});
    check("t1_req_cycles", req_cycles, 3);
    end_dl_and_wait(50);

    // Partial trailing word flushed on download end.
    clear_logs(); ack_delay = 1;
    start_dl();
    for (int i = 0; i < 6; i++) send_byte(25'h100 + 25'(i), 8'hAA + 8'(i * 17));
    end_dl_and_wait(50);
    check("t2_nwrites", wlog.size(), 2);
    check("t2_write0", (wlog.size() > 0) ? wlog[0] : 55'hx, {23'h40, 32'hDDCCBBAA});
    check("t2_write1", (wlog.size() > 1) ? wlog[1] : 55'hx, {23'h41, 32'h0000FFEE});
    check("t2_done_busy", {done, busy}, 2'b10);

    // Ack withheld: word 0 in flight, word 1 pending, word 2 lost.
    clear_logs(); ack_delay = 20;
    start_dl();
    for (int i = 0; i < 12; i++) send_byte(25'(i), 8'(i + 1));
    check("t3_overflow", overflow, 1);
    end_dl_and_wait(200);
    check("t3_nwrites", wlog.size(), 2);
    check("t3_write0", (wlog.size() > 0) ? wlog[0] : 55'hx, {23'h0, 32'h04030201});
    check("t3_write1", (wlog.size() > 1) ? wlog[1] : 55'hx, {23'h1, 32'h08070605});
    check("t3_ovf_sticky", overflow, 1);
`ifdef ROM_LOADER_CHECKSUM_EN
    check("t3_checksum", checksum, 8'h4E);
`else
    check("t3_checksum", checksum, 8'h00);
`endif

    // Second download: done and overflow clear on the next cycle, checksum restarts.
    clear_logs(); ack_delay = 0;
    start_dl();
    check("t6_restart", {done, busy, overflow, checksum}, {3'b010, 8'h00});
    send_byte(25'h0, 8'hFF); send_byte(25'h1, 8'h02);
`ifdef ROM_LOADER_CHECKSUM_EN
    check("t5_checksum", checksum, 8'h01);
`else
    check("t5_checksum", checksum, 8'h00);
`endif
    end_dl_and_wait(50);
    check("t5_flush", (wlog.size() > 0) ? wlog[0] : 55'hx, {23'h0, 32'h000002FF});

    // Rising download edge during FLUSH is ignored; a later edge restarts.
    clear_logs(); ack_delay = 8;
    start_dl();
    for (int i = 0; i < 5; i++) send_byte(25'h20 + 25'(i), 8'(8'h50 + i));
    ioctl_download = 1'b0;
    tick(); tick();
    check("t7_in_flush", {busy, done}, 2'b10);
    ioctl_download = 1'b1;
    for (int n = 0; n < 60 && !done; n++) tick();
    repeat (3) tick();
    check("t7_stays_done", {busy, done}, 2'b01);
    ioctl_download = 1'b0;
    tick();
    start_dl();
    check("t7_reenter", {busy, done}, 2'b10);
    end_dl_and_wait(50);
    check("t7_nwrites", wlog.size(), 2);

    // Reset while a request is outstanding; a later ack is ignored.
    clear_logs(); ack_delay = 30;
    start_dl();
    send_byte(25'h8, 8'h01); send_byte(25'h9, 8'h02); send_byte(25'hA, 8'h03); send_byte(25'hB, 8'h04);
    tick();
    check("t4_req_before", sdram_req, 1);
    reset_n = 1'b0;
    #1;
    check("t4_req_dropped", {sdram_req, sdram_we, busy, done, overflow}, 5'b0);
    check("t4_bus_zero", {sdram_addr, sdram_data, checksum}, 0);
    ioctl_download = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    ack_force = 1'b1;
    tick();
    ack_force = 1'b0;
    tick();
    check("t4_ack_ignored", {sdram_req, busy, done}, 3'b000);
    check("t4_no_write", wlog.size(), 0);

    // Randomized downloads.
    for (int d = 0; d < 20; d++) begin
      ack_delay = $urandom_range(0, 6);
      base      = 25'($urandom_range(0, 1 << 20));
      nbytes    = $urandom_range(1, 24);
      start_dl();
      for (int i = 0; i < nbytes; i++) begin
        if ($urandom_range(0, 7) == 0) base = 25'($urandom_range(0, 1 << 20));
        send_byte(base, 8'($urandom));
        base = base + 25'd1;
        repeat ($urandom_range(0, 2)) tick();
      end
      end_dl_and_wait(300);
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
